// File: rtl/cond_pkg.sv
// Shared types for the Execute-stage conditional-execution slice.
package cond_pkg;

  // ARM condition field encodings; NV (1111) never executes.
  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  // Bit positions inside the {N,Z,C,V} flag vector.
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // Controls carried by the D->E register.
  typedef struct packed {
    logic       pcsrc;
    logic       regwrite;
    logic       memtoreg;
    logic       memwrite;
    logic       branch;
    logic [1:0] flagwrite;
    cond_e      cond;
  } ctrl_e_t;

  // Controls carried by the E->M register.
  typedef struct packed {
    logic pcsrc;
    logic regwrite;
    logic memtoreg;
    logic memwrite;
  } ctrl_m_t;

endpackage

// File: rtl/flag_reg.sv
// Architectural NZCV register with independent N/Z and C/V write groups.
module flag_reg
  import cond_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] we,     // [1]=N,Z group, [0]=C,V group
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] flags_q;
  logic [3:0] flags_d;

  // Merge the enabled groups into the held flag value.
  always_comb begin
    flags_d = flags_q;
    if (we[1]) begin
      flags_d[FLAG_N] = d[FLAG_N];
      flags_d[FLAG_Z] = d[FLAG_Z];
    end
    if (we[0]) begin
      flags_d[FLAG_C] = d[FLAG_C];
      flags_d[FLAG_V] = d[FLAG_V];
    end
  end

  // Flag state register.
  always_ff @(posedge clk) begin
    if (reset) flags_q <= '0;
    else       flags_q <= flags_d;
  end

  assign q = flags_q;

endmodule

// File: rtl/cond_stage.sv
// Execute-stage conditional execution: D->E register, condition check,
// control gating, NZCV update and the E->M control register.
module cond_stage
  import cond_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       StallE,
  input  logic       FlushE,
  input  logic       PCSrcD,
  input  logic       RegWriteD,
  input  logic       MemtoRegD,
  input  logic       MemWriteD,
  input  logic       BranchD,
  input  logic [1:0] FlagWriteD,
  input  logic [3:0] CondD,
  input  logic [3:0] ALUFlagsE,
  output logic       CondExE,
  output logic       BranchTakenE,
  output logic       PCSrcE,
  output logic [3:0] Flags,
  output logic       PCSrcM,
  output logic       RegWriteM,
  output logic       MemtoRegM,
  output logic       MemWriteM
);

  ctrl_e_t    e_q, e_d;
  ctrl_m_t    m_q, m_d;
  logic       cond_ex;
  logic       fn, fz, fc, fv;
  logic       ge, hi, gt;
  logic       branch_taken;
  logic [1:0] flag_we;

  // D->E next value: flush beats stall, stall holds.
  always_comb begin
    e_d = e_q;
    if (FlushE) begin
      e_d = '0;
    end else if (!StallE) begin
      e_d.pcsrc     = PCSrcD;
      e_d.regwrite  = RegWriteD;
      e_d.memtoreg  = MemtoRegD;
      e_d.memwrite  = MemWriteD;
      e_d.branch    = BranchD;
      e_d.flagwrite = FlagWriteD;
      e_d.cond      = cond_e'(CondD);
    end
  end

  // D->E control register.
  always_ff @(posedge clk) begin
    if (reset) e_q <= '0;
    else       e_q <= e_d;
  end

  assign fn = Flags[FLAG_N];
  assign fz = Flags[FLAG_Z];
  assign fc = Flags[FLAG_C];
  assign fv = Flags[FLAG_V];
  assign ge = (fn == fv);
  assign hi = fc & ~fz;
  assign gt = ~fz & ge;

  // Condition evaluation against the registered flags.
  always_comb begin
    cond_ex = 1'b0;
    case (e_q.cond)
      COND_EQ: cond_ex = fz;
      COND_NE: cond_ex = ~fz;
      COND_CS: cond_ex = fc;
      COND_CC: cond_ex = ~fc;
      COND_MI: cond_ex = fn;
      COND_PL: cond_ex = ~fn;
      COND_VS: cond_ex = fv;
      COND_VC: cond_ex = ~fv;
      COND_HI: cond_ex = hi;
      COND_LS: cond_ex = ~hi;
      COND_GE: cond_ex = ge;
      COND_LT: cond_ex = ~ge;
      COND_GT: cond_ex = gt;
      COND_LE: cond_ex = ~gt;
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  assign branch_taken = e_q.branch & cond_ex;
  assign CondExE      = cond_ex;
  assign BranchTakenE = branch_taken;
  assign PCSrcE       = (e_q.pcsrc & cond_ex) | branch_taken;

  // A stalled setter is held in E, so writing only when unstalled gives one update.
  assign flag_we = e_q.flagwrite & {2{cond_ex & ~StallE}};

  flag_reg u_flag_reg (
    .clk   (clk),
    .reset (reset),
    .we    (flag_we),
    .d     (ALUFlagsE),
    .q     (Flags)
  );

  // E->M next value: gated controls, or a bubble while E is stalled.
  always_comb begin
    m_d = '0;
    if (!StallE) begin
      m_d.pcsrc    = PCSrcE;
      m_d.regwrite = e_q.regwrite & cond_ex;
      m_d.memtoreg = e_q.memtoreg;
      m_d.memwrite = e_q.memwrite & cond_ex;
    end
  end

  // E->M control register.
  always_ff @(posedge clk) begin
    if (reset) m_q <= '0;
    else       m_q <= m_d;
  end

  assign PCSrcM    = m_q.pcsrc;
  assign RegWriteM = m_q.regwrite;
  assign MemtoRegM = m_q.memtoreg;
  assign MemWriteM = m_q.memwrite;

endmodule

// File: tb/tb_cond_stage.sv
// Scoreboard bench for cond_stage: driver pushes expected outputs from a
// behavioural model, a negedge monitor pops and compares.
module tb_cond_stage;

  logic       clk = 1'b0;
  logic       reset, StallE, FlushE;
  logic       PCSrcD, RegWriteD, MemtoRegD, MemWriteD, BranchD;
  logic [1:0] FlagWriteD;
  logic [3:0] CondD, ALUFlagsE;
  logic       CondExE, BranchTakenE, PCSrcE;
  logic [3:0] Flags;
  logic       PCSrcM, RegWriteM, MemtoRegM, MemWriteM;

  always #5 clk = ~clk;

  cond_stage dut (
    .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE),
    .PCSrcD(PCSrcD), .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD),
    .MemWriteD(MemWriteD), .BranchD(BranchD), .FlagWriteD(FlagWriteD),
    .CondD(CondD), .ALUFlagsE(ALUFlagsE), .CondExE(CondExE),
    .BranchTakenE(BranchTakenE), .PCSrcE(PCSrcE), .Flags(Flags),
    .PCSrcM(PCSrcM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
    .MemWriteM(MemWriteM)
  );

  typedef struct {
    bit       rst, stall, flush;
    bit       pcsrc, regw, mtr, memw, br;
    bit [1:0] fw;
    bit [3:0] cond;
    bit [3:0] alu;
  } stim_t;

  typedef struct {
    int       cyc;
    bit [2:0] ecomb;   // {CondExE, BranchTakenE, PCSrcE}
    bit [3:0] flags;
    bit [3:0] mout;    // {PCSrcM, RegWriteM, MemtoRegM, MemWriteM}
  } exp_t;

  exp_t     sb[$];
  int       n_checks = 0;
  int       n_fail   = 0;
  int       cyc      = 0;
  bit       drv_done = 0;

  // Reference model: the instruction sitting in E, the flags, the M outputs.
  stim_t    mdl_e;
  bit [3:0] mdl_flags;
  bit [3:0] mdl_m;

  // ARM condition rules straight from the architecture definition.
  function automatic bit cond_ok(input bit [3:0] c, input bit [3:0] f);
    bit n, z, cf, v;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cf;
      4'd3:  return !cf;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cf && !z;
      4'd9:  return !(cf && !z);
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  // One cycle: apply inputs, predict this cycle's outputs, advance at the edge.
  task automatic drive(input stim_t s, input bit chk);
    bit ce, bt, pc;
    exp_t x;
    reset = s.rst; StallE = s.stall; FlushE = s.flush;
    PCSrcD = s.pcsrc; RegWriteD = s.regw; MemtoRegD = s.mtr;
    MemWriteD = s.memw; BranchD = s.br; FlagWriteD = s.fw;
    CondD = s.cond; ALUFlagsE = s.alu;
    ce = cond_ok(mdl_e.cond, mdl_flags);
    bt = mdl_e.br && ce;
    pc = (mdl_e.pcsrc && ce) || bt;
    if (chk) begin
      x.cyc = cyc; x.ecomb = {ce, bt, pc}; x.flags = mdl_flags; x.mout = mdl_m;
      sb.push_back(x);
    end
    @(posedge clk);
    if (s.rst) begin
      mdl_e = idle(); mdl_flags = 4'b0000; mdl_m = 4'b0000;
    end else begin
      if (ce && !s.stall) begin
        if (mdl_e.fw[1]) mdl_flags[3:2] = s.alu[3:2];
        if (mdl_e.fw[0]) mdl_flags[1:0] = s.alu[1:0];
      end
      mdl_m = s.stall ? 4'b0000 : {pc, mdl_e.regw && ce, mdl_e.mtr, mdl_e.memw && ce};
      if (s.flush)       mdl_e = idle();
      else if (!s.stall) mdl_e = s;
    end
    cyc++;
    #1;
  endtask

  // Issue an instruction into D with the given ALU flags for the E instruction.
  task automatic instr(input bit [3:0] cond, input bit [1:0] fw, input bit br,
                       input bit regw, input bit memw, input bit [3:0] alu);
    stim_t s;
    s = idle();
    s.cond = cond; s.fw = fw; s.br = br; s.regw = regw; s.memw = memw;
    s.alu = alu;
    drive(s, 1'b1);
  endtask

  // Monitor: compare whatever the scoreboard expects for this cycle.
  always @(negedge clk) begin
    exp_t x;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      n_checks++;
      if ({CondExE, BranchTakenE, PCSrcE} !== x.ecomb) begin
        n_fail++;
        $display("FAIL e_comb cyc=%0d got %b expected %b", x.cyc,
                 {CondExE, BranchTakenE, PCSrcE}, x.ecomb);
      end
      n_checks++;
      if (Flags !== x.flags) begin
        n_fail++;
        $display("FAIL flags cyc=%0d got %b expected %b", x.cyc, Flags, x.flags);
      end
      n_checks++;
      if ({PCSrcM, RegWriteM, MemtoRegM, MemWriteM} !== x.mout) begin
        n_fail++;
        $display("FAIL m_ctrl cyc=%0d got %b expected %b", x.cyc,
                 {PCSrcM, RegWriteM, MemtoRegM, MemWriteM}, x.mout);
      end
    end
  end

  initial begin
    stim_t s;
    mdl_e = idle(); mdl_flags = '0; mdl_m = '0;
    // Reset for two cycles; the first edge establishes known state.
    s = idle(); s.rst = 1;
    drive(s, 1'b0);
    drive(s, 1'b1);
    s.rst = 0;
    drive(s, 1'b1);

    // Flag setter (AL, fw=11) then BEQ; setter's ALU result is 0100.
    instr(4'hE, 2'b11, 0, 0, 0, 4'b0000);
    instr(4'h0, 2'b00, 1, 0, 0, 4'b0100);
    instr(4'hE, 2'b00, 0, 0, 0, 4'b0000);

    // Set 1111, then partial N/Z update with 0000 -> 0011.
    instr(4'hE, 2'b11, 0, 0, 0, 4'b0000);
    instr(4'hE, 2'b10, 0, 0, 0, 4'b1111);
    instr(4'hE, 2'b00, 0, 0, 0, 4'b0000);
    instr(4'hE, 2'b00, 0, 0, 0, 4'b0000);

    // Z=1, then NE with writes and flag update must be squashed.
    instr(4'hE, 2'b11, 0, 0, 0, 4'b0000);
    instr(4'h1, 2'b11, 0, 1, 1, 4'b0100);
    instr(4'hE, 2'b00, 0, 0, 0, 4'b1011);
    instr(4'hE, 2'b00, 0, 0, 0, 4'b0000);

    // Signed compares: 1001 -> GE/LT; 1000 -> LT/GT; 0000 -> GT; NV.
    instr(4'hE, 2'b11, 0, 0, 0, 4'b0000);
    instr(4'hA, 2'b00, 1, 1, 0, 4'b1001);
    instr(4'hB, 2'b00, 1, 1, 0, 4'b0000);
    instr(4'hE, 2'b11, 0, 0, 0, 4'b0000);
    instr(4'hB, 2'b00, 1, 1, 0, 4'b1000);
    instr(4'hC, 2'b00, 1, 1, 0, 4'b0000);
    instr(4'hE, 2'b11, 0, 0, 0, 4'b0000);
    instr(4'hC, 2'b00, 1, 1, 1, 4'b0000);
    instr(4'hF, 2'b00, 1, 1, 1, 4'b0000);
    instr(4'hE, 2'b00, 0, 0, 0, 4'b0000);

    // Setter stalled two cycles in E with changing ALU flags.
    instr(4'hE, 2'b11, 0, 1, 0, 4'b0000);
    s = idle(); s.stall = 1; s.alu = 4'b1010; s.regw = 1; s.cond = 4'hE;
    drive(s, 1'b1);
    s.alu = 4'b0101;
    drive(s, 1'b1);
    s.stall = 0; s.alu = 4'b1100;
    drive(s, 1'b1);
    instr(4'hE, 2'b00, 0, 0, 0, 4'b0011);
    // Stall and flush together: E becomes a bubble.
    instr(4'hE, 2'b00, 1, 1, 1, 4'b0000);
    s = idle(); s.stall = 1; s.flush = 1; s.cond = 4'hE; s.br = 1;
    drive(s, 1'b1);
    instr(4'hE, 2'b00, 0, 0, 0, 4'b0000);
    instr(4'hE, 2'b00, 0, 0, 0, 4'b0000);

    // Randomised traffic including occasional mid-run reset.
    for (int i = 0; i < 1500; i++) begin
      s.rst   = ($urandom_range(0, 99) == 0);
      s.stall = ($urandom_range(0, 5) == 0);
      s.flush = ($urandom_range(0, 7) == 0);
      s.pcsrc = $urandom_range(0, 1);
      s.regw  = $urandom_range(0, 1);
      s.mtr   = $urandom_range(0, 1);
      s.memw  = $urandom_range(0, 1);
      s.br    = $urandom_range(0, 1);
      s.fw    = 2'($urandom_range(0, 3));
      s.cond  = 4'($urandom_range(0, 15));
      s.alu   = 4'($urandom_range(0, 15));
      drive(s, 1'b1);
    end
    drv_done = 1;
  end

  initial begin
    wait (drv_done);
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule
